// File: rtl/seq_divu.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divu
//  Description : Multi-cycle unsigned restoring divider for the DIVU path.
//                Accepts a dividend/divisor pair on a start strobe, produces
//                one quotient bit per clock and reports the result with a
//                one-cycle done pulse. Quotient, remainder and the
//                divide-by-zero flag hold until the next completion.
//
//  Ports       : clk    - clock, rising edge
//                reset  - synchronous, active-high reset
//                start  - request strobe, honoured only while ready=1
//                a, b   - dividend / divisor (unsigned), latched with start
//                ready  - a request would be accepted on this edge
//                busy   - iteration in progress
//                done   - one-cycle completion pulse
//                q, r   - quotient / remainder (registered, held)
//                dbz    - divide-by-zero flag of the last completed request
//
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dbz
);

  // Counter must be able to hold the value WIDTH itself.
  localparam int              CW         = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   c_cnt_init = CW'(WIDTH);
  localparam logic [CW-1:0]   c_cnt_last = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_quo;   // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] r_rem;   // partial remainder, always < r_div while running
  logic [WIDTH-1:0] r_div;   // latched divisor
  logic [CW-1:0]    r_cnt;   // remaining iterations

  logic             w_accept;
  logic             w_b_zero;
  logic             w_last;
  logic [WIDTH:0]   w_rem_t;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;

  // --------------------------------------------------------------------------
  // Status outputs decode straight from the state register, so there is no
  // path from start/a/b to any output.
  // --------------------------------------------------------------------------
  assign ready = (r_state == S_IDLE) || (r_state == S_DONE);
  assign busy  = (r_state == S_RUN);
  assign done  = (r_state == S_DONE);

  assign w_accept = ready && start;
  assign w_b_zero = (b == '0);
  assign w_last   = (r_cnt == c_cnt_last);

  // --------------------------------------------------------------------------
  // One restoring step. The shifted remainder needs WIDTH+1 bits: the
  // partial remainder is below the divisor, so doubling it plus one bit can
  // exceed WIDTH bits but never WIDTH+1.
  // --------------------------------------------------------------------------
  assign w_rem_t    = {r_rem, r_quo[WIDTH-1]};
  assign w_ge       = (w_rem_t >= {1'b0, r_div});
  assign w_rem_next = w_ge ? WIDTH'(w_rem_t - {1'b0, r_div}) : w_rem_t[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. DONE behaves like IDLE for acceptance, which gives
  // back-to-back requests without a dead cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_next = w_b_zero ? S_DONE : S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and result registers. Results are written only at completion,
  // so the previous answer stays visible while a new divide is running.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_quo <= '0;
      r_rem <= '0;
      r_div <= '0;
      r_cnt <= '0;
      q     <= '0;
      r     <= '0;
      dbz   <= 1'b0;
    end else if (w_accept) begin
      r_div <= b;
      if (w_b_zero) begin
        // Divide by zero completes immediately with the conventional result.
        q   <= '1;
        r   <= a;
        dbz <= 1'b1;
      end else begin
        r_quo <= a;
        r_rem <= '0;
        r_cnt <= c_cnt_init;
      end
    end else if (r_state == S_RUN) begin
      r_quo <= w_quo_next;
      r_rem <= w_rem_next;
      r_cnt <= r_cnt - c_cnt_last;
      if (w_last) begin
        q   <= w_quo_next;
        r   <= w_rem_next;
        dbz <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_divu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_divu
//  Description : Directed self-checking bench for seq_divu (WIDTH = 32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divu;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         dbz;

  int n_run  = 0;
  int n_fail = 0;

  seq_divu #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r),
    .dbz   (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; raises start for one cycle. Returns at the negedge
  // one cycle after the accepting edge.
  task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb);
    start = 1'b1;
    a     = va;
    b     = vb;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts cycles since the accepting edge until done is seen (bounded).
  task automatic wait_done(input int lat0, output int lat, output int busy_cnt);
    lat      = lat0;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edbz, input int elat);
    int lat;
    int bc;
    issue(va, vb);
    wait_done(1, lat, bc);
    check({tag, "_lat"}, 64'(lat), 64'(elat));
    check({tag, "_q"},   64'(q),   64'(eq));
    check({tag, "_r"},   64'(r),   64'(er));
    check({tag, "_dbz"}, 64'(dbz), 64'(edbz));
  endtask

  logic [W-1:0] tv_a [8];
  logic [W-1:0] tv_b [8];
  logic [W-1:0] tv_q [8];
  logic [W-1:0] tv_r [8];
  logic         tv_z [8];

  initial begin
    int lat;
    int bc;
    int saw_done;

    tv_a = '{32'd0,  32'd7, 32'd6, 32'h8000_0000, 32'd123456789, 32'hFFFF_FFFF, 32'd0,        32'd1};
    tv_b = '{32'd5,  32'd7, 32'd7, 32'd2,         32'd1000,      32'h0001_0000, 32'd0,        32'hFFFF_FFFF};
    tv_q = '{32'd0,  32'd1, 32'd0, 32'h4000_0000, 32'd123456,    32'h0000_FFFF, 32'hFFFF_FFFF, 32'd0};
    tv_r = '{32'd0,  32'd0, 32'd6, 32'd0,         32'd789,       32'h0000_FFFF, 32'd0,        32'd1};
    tv_z = '{1'b0,   1'b0,  1'b0,  1'b0,          1'b0,          1'b0,          1'b1,         1'b0};

    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_done",  64'(done),  64'd0);
    check("rst_q",     64'(q),     64'd0);
    check("rst_r",     64'(r),     64'd0);
    check("rst_dbz",   64'(dbz),   64'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: basic divide, latency, busy length, single done pulse, hold
    issue(32'd100, 32'd7);
    wait_done(1, lat, bc);
    check("t1_lat",  64'(lat), 64'd33);
    check("t1_busy", 64'(bc),  64'd32);
    check("t1_q",    64'(q),   64'd14);
    check("t1_r",    64'(r),   64'd2);
    check("t1_dbz",  64'(dbz), 64'd0);
    @(negedge clk);
    check("t1_done_pulse", 64'(done),  64'd0);
    check("t1_ready_idle", 64'(ready), 64'd1);
    repeat (10) @(negedge clk);
    check("t1_q_hold", 64'(q), 64'd14);
    check("t1_r_hold", 64'(r), 64'd2);

    // 2: boundary operands
    run_vec("t2a", 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0, 1'b0, 33);
    @(negedge clk);
    run_vec("t2b", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'd0, 1'b0, 33);
    @(negedge clk);
    run_vec("t2c", 32'd3,         32'd10,        32'd0,         32'd3, 1'b0, 33);
    @(negedge clk);

    // 3: divide by zero, then a normal request clears dbz
    run_vec("t3a", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
    @(negedge clk);
    run_vec("t3b", 32'd9, 32'd3, 32'd3,         32'd0, 1'b0, 33);
    @(negedge clk);

    // 4: start while busy ignored; back-to-back from the DONE cycle
    issue(32'd100, 32'd7);
    repeat (8) @(negedge clk);
    start = 1'b1;
    a     = 32'd1;
    b     = 32'd1;
    @(negedge clk);
    start = 1'b0;
    check("t4_busy_ign", 64'(busy), 64'd1);
    wait_done(10, lat, bc);
    check("t4a_lat", 64'(lat), 64'd33);
    check("t4a_q",   64'(q),   64'd14);
    check("t4a_r",   64'(r),   64'd2);
    issue(32'd50, 32'd6);
    check("t4_b2b_busy", 64'(busy), 64'd1);
    check("t4_q_held",   64'(q),    64'd14);
    wait_done(1, lat, bc);
    check("t4b_lat", 64'(lat), 64'd33);
    check("t4b_q",   64'(q),   64'd8);
    check("t4b_r",   64'(r),   64'd2);
    @(negedge clk);

    // 5: reset mid-operation aborts without done
    issue(32'd1000, 32'd3);
    repeat (13) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_busy",  64'(busy),  64'd0);
    check("t5_ready", 64'(ready), 64'd1);
    check("t5_done",  64'(done),  64'd0);
    check("t5_q",     64'(q),     64'd0);
    check("t5_r",     64'(r),     64'd0);
    saw_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1;
    end
    check("t5_no_done", 64'(saw_done), 64'd0);
    run_vec("t5b", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 33);
    @(negedge clk);

    // 6: extra directed pairs (a=0, b=a, b>a, powers of two, b=0 with a=0)
    for (int i = 0; i < 8; i++) begin
      run_vec($sformatf("t6_%0d", i), tv_a[i], tv_b[i], tv_q[i], tv_r[i], tv_z[i],
              tv_z[i] ? 1 : 33);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
